// File: rtl/floatingpoint.sv
// IEEE-754 single-precision type shared by the adder and its dispatcher,
// plus the quiet-NaN constant and the zero test used for the adder bypass.
package floatingpoint;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } float;

    localparam logic [31:0] FLT_QNAN = 32'h7FC00000;

    // Exponent and mantissa both zero; sign deliberately ignored.
    function automatic logic isZero(input float f);
        return (f.exponent == 8'd0) && (f.mantissa == 23'd0);
    endfunction

endpackage

// File: rtl/float_add_dispatch_fifo.sv
// Synchronous FIFO holding tagged operand pairs ahead of the adder.
// The head entry is read combinationally so the dispatcher can pop and
// register it in the same cycle.
module float_pair_fifo #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         push,
    input  logic [64+TAG_W-1:0]          push_data,
    input  logic                         pop,
    output logic [64+TAG_W-1:0]          pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int W     = 64 + TAG_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Guard against overflow/underflow even if the caller misbehaves.
    assign do_push = push && (count_q != CNT_W'(DEPTH));
    assign do_pop  = pop && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/float_add_dispatch.sv
// Dispatcher in front of the single-precision adder: queues tagged operand
// pairs, issues them one at a time, bypasses zero operands, bounds each wait.
module float_add_dispatch
    import floatingpoint::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  float                        InOp1,
    input  float                        InOp2,
    input  logic [TAG_W-1:0]            InTag,
    input  logic                        InValid,
    output logic                        InReady,
    output float                        AddOp1,
    output float                        AddOp2,
    output logic                        AddInputValid,
    input  float                        AddResult,
    input  logic                        AddResultValid,
    output float                        OutResult,
    output logic [TAG_W-1:0]            OutTag,
    output logic                        OutTimeout,
    output logic                        OutValid,
    input  logic                        OutReady,
    output logic [$clog2(DEPTH+1)-1:0]  Occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam int ENT_W = 64 + TAG_W;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t             state_q, state_d;
    float               add_op1_q, add_op1_d;
    float               add_op2_q, add_op2_d;
    logic               add_valid_q, add_valid_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    float               out_result_q, out_result_d;
    logic               out_timeout_q, out_timeout_d;
    logic               out_valid_q, out_valid_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;

    logic               fifo_push, fifo_pop;
    logic [ENT_W-1:0]   fifo_head;
    logic [OCC_W-1:0]   fifo_count;
    float               head_op1, head_op2;
    logic [TAG_W-1:0]   head_tag;
    logic               head_z1, head_z2, head_bypass;
    float               bypass_val;

    assign InReady   = !Reset && (fifo_count != OCC_W'(DEPTH));
    assign fifo_push = InValid && InReady;

    float_pair_fifo #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_fifo (
        .Clock     (Clock),
        .Reset     (Reset),
        .push      (fifo_push),
        .push_data ({InTag, InOp1, InOp2}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .count     (fifo_count)
    );

    assign head_tag    = fifo_head[ENT_W-1:64];
    assign head_op1    = fifo_head[63:32];
    assign head_op2    = fifo_head[31:0];
    assign head_z1     = isZero(head_op1);
    assign head_z2     = isZero(head_op2);
    assign head_bypass = head_z1 || head_z2;

    // Two zeros keep a negative sign only if both were negative.
    always_comb begin
        bypass_val = head_op1;
        if (head_z1 && head_z2) begin
            bypass_val = {head_op1.sign & head_op2.sign, 31'b0};
        end else if (head_z1) begin
            bypass_val = head_op2;
        end
    end

    always_comb begin
        state_d       = state_q;
        add_op1_d     = add_op1_q;
        add_op2_d     = add_op2_q;
        add_valid_d   = 1'b0;
        tag_d         = tag_q;
        out_result_d  = out_result_q;
        out_timeout_d = out_timeout_q;
        out_valid_d   = out_valid_q;
        wait_cnt_d    = wait_cnt_q;
        fifo_pop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (fifo_count != '0) begin
                    fifo_pop  = 1'b1;
                    add_op1_d = head_op1;
                    add_op2_d = head_op2;
                    tag_d     = head_tag;
                    if (head_bypass) begin
                        out_result_d  = bypass_val;
                        out_timeout_d = 1'b0;
                        out_valid_d   = 1'b1;
                        state_d       = HOLD;
                    end else begin
                        add_valid_d = 1'b1;
                        state_d     = ISSUE;
                    end
                end
            end
            ISSUE: begin
                wait_cnt_d = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                // ResultValid seen on the first WAIT cycle predates our issue.
                if (AddResultValid && (wait_cnt_q != '0)) begin
                    out_result_d  = AddResult;
                    out_timeout_d = 1'b0;
                    out_valid_d   = 1'b1;
                    state_d       = HOLD;
                end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    out_result_d  = FLT_QNAN;
                    out_timeout_d = 1'b1;
                    out_valid_d   = 1'b1;
                    state_d       = HOLD;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (OutReady) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q       <= IDLE;
            add_op1_q     <= '0;
            add_op2_q     <= '0;
            add_valid_q   <= 1'b0;
            tag_q         <= '0;
            out_result_q  <= '0;
            out_timeout_q <= 1'b0;
            out_valid_q   <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            add_op1_q     <= add_op1_d;
            add_op2_q     <= add_op2_d;
            add_valid_q   <= add_valid_d;
            tag_q         <= tag_d;
            out_result_q  <= out_result_d;
            out_timeout_q <= out_timeout_d;
            out_valid_q   <= out_valid_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    assign AddOp1        = add_op1_q;
    assign AddOp2        = add_op2_q;
    assign AddInputValid = add_valid_q;
    assign OutResult     = out_result_q;
    assign OutTag        = tag_q;
    assign OutTimeout    = out_timeout_q;
    assign OutValid      = out_valid_q;
    assign Occupancy     = fifo_count;

endmodule

// File: tb/tb_float_add_dispatch.sv
// Scoreboard bench for float_add_dispatch with a behavioural adder model
// whose latency, silence and stale-valid behaviour are set per test.
module tb_float_add_dispatch;

    localparam int DEPTH   = 4;
    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 64;
    localparam int OCC_W   = $clog2(DEPTH + 1);

    logic               Clock = 1'b0;
    logic               Reset;
    logic [31:0]        InOp1, InOp2;
    logic [TAG_W-1:0]   InTag;
    logic               InValid;
    logic               InReady;
    logic [31:0]        AddOp1, AddOp2;
    logic               AddInputValid;
    logic [31:0]        AddResult;
    logic               AddResultValid;
    logic [31:0]        OutResult;
    logic [TAG_W-1:0]   OutTag;
    logic               OutTimeout;
    logic               OutValid;
    logic               OutReady;
    logic [OCC_W-1:0]   Occupancy;

    float_add_dispatch #(
        .DEPTH   (DEPTH),
        .TAG_W   (TAG_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .InOp1          (InOp1),
        .InOp2          (InOp2),
        .InTag          (InTag),
        .InValid        (InValid),
        .InReady        (InReady),
        .AddOp1         (AddOp1),
        .AddOp2         (AddOp2),
        .AddInputValid  (AddInputValid),
        .AddResult      (AddResult),
        .AddResultValid (AddResultValid),
        .OutResult      (OutResult),
        .OutTag         (OutTag),
        .OutTimeout     (OutTimeout),
        .OutValid       (OutValid),
        .OutReady       (OutReady),
        .Occupancy      (Occupancy)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
        logic             to;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   out_cnt  = 0;
    int   issue_cnt = 0;
    int   issue_cyc = 0;
    int   ov_rise_cyc = 0;
    int   acc_cyc  = 0;
    int   fire_cyc = 0;
    logic ov_prev  = 1'b0;
    logic [31:0] seen_op1 = '0, seen_op2 = '0;

    // Adder model controls
    logic        a_never = 1'b0;
    logic        a_stale = 1'b0;
    logic        late_pulse = 1'b0;
    int          a_delay = 5;
    logic [31:0] a_answer = '0;
    logic        pend = 1'b0;
    int          pend_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    always @(posedge Clock) cyc <= cyc + 1;

    // Output monitor / scoreboard
    always @(negedge Clock) begin
        exp_t e;
        if (AddInputValid) begin
            issue_cnt++;
            issue_cyc = cyc;
            seen_op1  = AddOp1;
            seen_op2  = AddOp2;
        end
        if (OutValid && !ov_prev) ov_rise_cyc = cyc;
        ov_prev = OutValid;
        if (OutValid && OutReady) begin
            $display("cycle %0d out tag=%0d result=%h timeout=%b", cyc, OutTag, OutResult, OutTimeout);
            if (sb.size() == 0) begin
                check("unexpected_out", 64'(OutValid), 64'(0));
            end else begin
                e = sb.pop_front();
                check("result", 64'(OutResult), 64'(e.res));
                check("tag", 64'(OutTag), 64'(e.tag));
                check("timeout", 64'(OutTimeout), 64'(e.to));
            end
            out_cnt++;
        end
    end

    // Behavioural adder: answers a_delay cycles after the InputValid cycle
    initial begin
        AddResult      = '0;
        AddResultValid = 1'b0;
        forever begin
            @(posedge Clock);
            #1;
            AddResultValid = a_stale;
            AddResult      = a_stale ? 32'hDEADBEEF : 32'h0;
            if (late_pulse) begin
                AddResultValid = 1'b1;
                AddResult      = 32'h12345678;
                late_pulse     = 1'b0;
            end
            if (pend) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    AddResultValid = 1'b1;
                    AddResult      = a_answer;
                    pend           = 1'b0;
                    a_stale        = 1'b0;
                    fire_cyc       = cyc;
                end
            end
            if (AddInputValid && !a_never) begin
                pend     = 1'b1;
                pend_cnt = a_delay;
            end
        end
    end

    task automatic push_req(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag,
                            input logic [31:0] res, input logic to);
        logic ok;
        ok = 1'b0;
        @(posedge Clock); #1;
        InOp1 = a; InOp2 = b; InTag = tag; InValid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge Clock);
            if (InReady) begin
                ok = 1'b1;
                break;
            end
            @(posedge Clock); #1;
        end
        if (!ok) begin
            check("push_ready", 64'(0), 64'(1));
        end else begin
            acc_cyc = cyc;
            sb.push_back('{res: res, tag: tag, to: to});
        end
        @(posedge Clock); #1;
        InValid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 300 && sb.size() != 0; k++) @(negedge Clock);
        if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'(0));
        @(negedge Clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int ic0, acc_n, ov_n;
        Reset = 1'b1; InValid = 1'b0; InOp1 = '0; InOp2 = '0; InTag = '0; OutReady = 1'b1;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check("rst_inready", 64'(InReady), 64'(0));
        check("rst_occ", 64'(Occupancy), 64'(0));
        check("rst_outvalid", 64'(OutValid), 64'(0));
        check("rst_addiv", 64'(AddInputValid), 64'(0));
        check("rst_outresult", 64'(OutResult), 64'(0));
        check("rst_outtag", 64'(OutTag), 64'(0));
        check("rst_timeout", 64'(OutTimeout), 64'(0));
        check("rst_addop", 64'({AddOp1, AddOp2}), 64'(0));
        @(posedge Clock); #1;
        Reset = 1'b0;
        @(negedge Clock);
        check("post_rst_inready", 64'(InReady), 64'(1));

        // Adder path: 1.0 + 2.0 = 3.0, answer 5 cycles after InputValid
        a_delay = 5; a_answer = 32'h40400000;
        ic0 = issue_cnt;
        push_req(32'h3F800000, 32'h40000000, 4'd5, 32'h40400000, 1'b0);
        wait_drain();
        check("add_issue_count", 64'(issue_cnt - ic0), 64'(1));
        check("add_issue_lat", 64'(issue_cyc - acc_cyc), 64'(2));
        check("add_out_lat", 64'(ov_rise_cyc - fire_cyc), 64'(1));
        check("add_op1", 64'(seen_op1), 64'(32'h3F800000));
        check("add_op2", 64'(seen_op2), 64'(32'h40000000));

        // Zero bypass
        ic0 = issue_cnt;
        push_req(32'h00000000, 32'h40490FDB, 4'd2, 32'h40490FDB, 1'b0);
        wait_drain();
        check("byp_lat", 64'(ov_rise_cyc - acc_cyc), 64'(2));
        push_req(32'h80000000, 32'h80000000, 4'd3, 32'h80000000, 1'b0);
        push_req(32'hC0A00000, 32'h80000000, 4'd4, 32'hC0A00000, 1'b0);
        push_req(32'h00000000, 32'h80000000, 4'd6, 32'h00000000, 1'b0);
        wait_drain();
        check("byp_no_issue", 64'(issue_cnt - ic0), 64'(0));

        // Backpressure: one entry sits in HOLD, so DEPTH+1 pushes get in
        OutReady = 1'b0;
        acc_n = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge Clock); #1;
            InOp1 = 32'h3F800000 + i; InOp2 = 32'h0; InTag = TAG_W'(8 + i); InValid = 1'b1;
            @(negedge Clock);
            if (InReady) begin
                acc_n++;
                sb.push_back('{res: 32'h3F800000 + i, tag: TAG_W'(8 + i), to: 1'b0});
            end
        end
        @(posedge Clock); #1;
        InValid = 1'b0;
        @(negedge Clock);
        check("full_accepted", 64'(acc_n), 64'(DEPTH + 1));
        check("full_occ", 64'(Occupancy), 64'(DEPTH));
        check("full_inready", 64'(InReady), 64'(0));
        OutReady = 1'b1;
        wait_drain();
        check("drain_occ", 64'(Occupancy), 64'(0));

        // Watchdog abort, then a normal request
        a_never = 1'b1;
        push_req(32'h3F800000, 32'h3F800000, 4'd6, 32'h7FC00000, 1'b1);
        wait_drain();
        check("to_lat", 64'(ov_rise_cyc - issue_cyc), 64'(TIMEOUT + 1));
        a_never = 1'b0; a_delay = 3; a_answer = 32'h40800000;
        push_req(32'h40000000, 32'h40000000, 4'd7, 32'h40800000, 1'b0);
        wait_drain();

        // ResultValid held high across ISSUE: first-WAIT-cycle value is stale
        a_stale = 1'b1; a_delay = 2; a_answer = 32'h40A00000;
        push_req(32'h40000000, 32'h40400000, 4'd9, 32'h40A00000, 1'b0);
        wait_drain();
        check("stale_lat", 64'(ov_rise_cyc - issue_cyc), 64'(3));

        // Reset in WAIT with two entries queued
        a_never = 1'b1;
        push_req(32'h3F800000, 32'h40000000, 4'd10, 32'h40400000, 1'b0);
        push_req(32'h00000000, 32'h3F800000, 4'd11, 32'h3F800000, 1'b0);
        push_req(32'h00000000, 32'h40000000, 4'd12, 32'h40000000, 1'b0);
        @(negedge Clock);
        check("pre_rst_occ", 64'(Occupancy), 64'(2));
        @(posedge Clock); #1;
        Reset = 1'b1;
        sb.delete();
        @(posedge Clock); #1;
        Reset = 1'b0;
        a_never = 1'b0;
        @(negedge Clock);
        check("mid_rst_occ", 64'(Occupancy), 64'(0));
        check("mid_rst_outvalid", 64'(OutValid), 64'(0));
        check("mid_rst_addiv", 64'(AddInputValid), 64'(0));
        ic0 = issue_cnt;
        late_pulse = 1'b1;
        ov_n = 0;
        repeat (10) begin
            @(negedge Clock);
            if (OutValid) ov_n++;
        end
        check("late_result_dropped", 64'(ov_n), 64'(0));
        check("idle_no_issue", 64'(issue_cnt - ic0), 64'(0));

        // Recovery after reset
        a_delay = 4; a_answer = 32'h40000000;
        push_req(32'h3F800000, 32'h3F800000, 4'd1, 32'h40000000, 1'b0);
        wait_drain();
        check("final_issue_lat", 64'(issue_cyc - acc_cyc), 64'(2));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
